reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Shares the two write ports of the 32-bit control register between two requesters.
//  Round-robin arbitration with a minimum ownership window.
//  Refreshes the owner's strobe every cycle, because the register clears whenever no
//  write strobe is high.
//  Sits directly in front of reg_control: wr1_o/data1_o/wr2_o/data2_o drive its wr1/data1/wr2/data2.
// PARAMETERS
//  DW        32  data width of both requesters and the register
//  MIN_HOLD  4   cycles an owner keeps the register before a competing request may win (>=1)
// PORTS
//  clk_i      in   1   clock, all logic on rising edge
//  rst_i      in   1   reset, synchronous, active-high
//  req1_i     in   1   requester 1 write request, level, held until ack1_o
//  data1_i    in   DW  requester 1 data, stable while req1_i high
//  req2_i     in   1   requester 2 write request, level, held until ack2_o
//  data2_i    in   DW  requester 2 data, stable while req2_i high
//  rel_i      in   1   current owner releases the register (returns it to 0)
//  ack1_o     out  1   one-cycle pulse: requester 1 write accepted
//  ack2_o     out  1   one-cycle pulse: requester 2 write accepted
//  wr1_o      out  1   write strobe to register port 1
//  data1_o    out  DW  data to register port 1 (0 when not owner)
//  wr2_o      out  1   write strobe to register port 2
//  data2_o    out  DW  data to register port 2 (0 when not owner)
//  owner_o    out  2   00 none, 01 requester 1, 10 requester 2
//  busy_o     out  1   owner present and hold window not yet expired
// BEHAVIOUR
//  Reset values: all outputs 0. state=IDLE, hold_cnt=0, rr_last=2 (requester 1 favoured first).
//  All outputs are registered.
//  States:
//   IDLE: no strobe, so the register reads 0.
//   OWN1: wr1_o=1 every cycle, data1_o=data_q.
//   OWN2: wr2_o=1 every cycle, data2_o=data_q.
//  Grant: a request sampled in cycle N gives ackX_o=1, wrX_o=1 and data latched into data_q
//   in cycle N+1. The register output updates in N+2.
//   On grant, hold_cnt is loaded with MIN_HOLD-1 and rr_last is set to the winner.
//  Ownership window: hold_cnt decrements to 0 and saturates there.
//   A non-owner request wins only when hold_cnt==0.
//   Until then the request stays pending: no ack, and nothing is dropped.
//  Owner re-request: accepted in any cycle, even inside the window.
//   It updates data_q, pulses ack and reloads hold_cnt.
//  Simultaneous requests:
//   In IDLE, the requester that is not rr_last wins.
//   In OWNx with hold_cnt==0, the non-owner wins over the owner's re-request.
//   The loser stays pending.
//  Release: rel_i in OWNx with hold_cnt==0 and no competing request goes to IDLE next cycle.
//   A pending request from the other requester supersedes the release and is granted instead.
//   The owner's own req in the same cycle wins over rel_i.
//   rel_i is ignored in IDLE and while hold_cnt!=0.
//  wr1_o and wr2_o are never high in the same cycle.
//  Each ack is exactly one cycle. A requester that drops req before its ack is never granted.
//  Reset mid-operation: next cycle all outputs are 0 and the FSM is in IDLE.
//   A pending ack is discarded, so the requester must re-request.
//  busy_o = (state!=IDLE) && (hold_cnt!=0).
//  hold_cnt width is $clog2(MIN_HOLD+1). MIN_HOLD=1 allows a switch on the cycle after a grant.
// STRUCTURE
//  Package reg_arb_pkg: typedef enum logic[1:0] {IDLE, OWN1, OWN2} arb_state_t;
//   owner encoding constants OWNER_NONE/OWNER_1/OWNER_2.
//  Sub-module hold_timer: load/decrement/saturating counter parameterised by MIN_HOLD,
//   with a zero_o flag.
//  Top level holds the FSM, the round-robin pointer, data_q and the output registers.
// TESTING
//  1. Reset, req1=1 with data1=0xDEAD_BEEF
//     -> ack1 pulses at +1, wr1 stays high, register=0xDEADBEEF at +2, owner=01.
//  2. In IDLE, req1 and req2 in the same cycle
//     -> req1 granted first; after MIN_HOLD=4 cycles req2 granted, then req1 again.
//  3. Owner 1 at hold_cnt=3, req2 asserted
//     -> no ack2 for 3 cycles; ack2 on the cycle after hold_cnt==0; wr1 falls as wr2 rises.
//  4. Owner 1 with hold expired, rel_i=1 and no req
//     -> IDLE next cycle; wr1=wr2=0; register reads 0 one cycle later.
//  5. rel_i with req2 pending after expiry
//     -> req2 granted, no IDLE cycle.
//     Owner re-request inside the window -> immediate ack and new data.
//  6. rst_i during OWN2 with req1 pending
//     -> all outputs 0 next cycle, no ack1; after reset req1 still high -> granted normally.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types for the control-register write arbiter: FSM states and owner encoding.
// Latency: n/a (types only); backpressure: n/a.
package reg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN1 = 2'd1,
        OWN2 = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_1    = 2'b01;
    localparam logic [1:0] OWNER_2    = 2'b10;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester/register-side bundle of the write arbiter; master = requesters, slave = arbiter.
// Latency: n/a (wiring only); backpressure: level requests held until their one-cycle ack.
interface reg_write_arbiter_if #(
    parameter int DW = 32
);
    logic          req1_i;
    logic [DW-1:0] data1_i;
    logic          req2_i;
    logic [DW-1:0] data2_i;
    logic          rel_i;
    logic          ack1_o;
    logic          ack2_o;
    logic          wr1_o;
    logic [DW-1:0] data1_o;
    logic          wr2_o;
    logic [DW-1:0] data2_o;
    logic [1:0]    owner_o;
    logic          busy_o;

    modport master (
        output req1_i, data1_i, req2_i, data2_i, rel_i,
        input  ack1_o, ack2_o, wr1_o, data1_o, wr2_o, data2_o, owner_o, busy_o
    );

    modport slave (
        input  req1_i, data1_i, req2_i, data2_i, rel_i,
        output ack1_o, ack2_o, wr1_o, data1_o, wr2_o, data2_o, owner_o, busy_o
    );
endinterface

// File: rtl/reg_write_arbiter_hold_timer.sv
// Ownership-window counter: loads MIN_HOLD-1 on grant, then counts down and saturates at 0.
// Latency: zero_o reflects the registered count; zero_nxt_o is the value it takes next cycle.
module hold_timer #(
    parameter int MIN_HOLD = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic zero_o,
    output logic zero_nxt_o
);
    localparam int CW = $clog2(MIN_HOLD + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MIN_HOLD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o     = (cnt_q == '0);
    assign zero_nxt_o = (cnt_d == '0);

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin sharing of the control register's two write ports with a minimum ownership window.
// Latency: request sampled in N -> ack/strobe/data in N+1; losers and in-window rivals stay pending.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int DW       = 32,
    parameter int MIN_HOLD = 4
) (
    input logic           clk_i,
    input logic           rst_i,
    reg_write_arbiter_if.slave bus
);
    arb_state_t    state_q, state_d;
    logic [1:0]    rr_last_q, rr_last_d;
    logic [DW-1:0] data_q, data_d;
    logic          grant1, grant2;
    logic          hold_zero, hold_zero_nxt;
    logic          r1, r2;

    logic          ack1_q, ack2_q, wr1_q, wr2_q, busy_q;
    logic [DW-1:0] data1_q, data2_q;
    logic [1:0]    owner_q;

    // A level request is still high during its own ack cycle; masking it there keeps acks single-cycle.
    assign r1 = bus.req1_i && !ack1_q;
    assign r2 = bus.req2_i && !ack2_q;

    hold_timer #(
        .MIN_HOLD (MIN_HOLD)
    ) u_hold_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (grant1 || grant2),
        .zero_o     (hold_zero),
        .zero_nxt_o (hold_zero_nxt)
    );

    always_comb begin
        state_d = state_q;
        grant1  = 1'b0;
        grant2  = 1'b0;
        case (state_q)
            IDLE: begin
                if (r1 && r2) begin
                    if (rr_last_q == OWNER_1) grant2 = 1'b1;
                    else                      grant1 = 1'b1;
                end else if (r1) begin
                    grant1 = 1'b1;
                end else if (r2) begin
                    grant2 = 1'b1;
                end
            end
            OWN1: begin
                if (r2 && hold_zero)           grant2  = 1'b1;
                else if (r1)                   grant1  = 1'b1;
                else if (bus.rel_i && hold_zero) state_d = IDLE;
            end
            OWN2: begin
                if (r1 && hold_zero)           grant1  = 1'b1;
                else if (r2)                   grant2  = 1'b1;
                else if (bus.rel_i && hold_zero) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (grant1)      state_d = OWN1;
        else if (grant2) state_d = OWN2;

        rr_last_d = rr_last_q;
        data_d    = data_q;
        if (grant1) begin
            rr_last_d = OWNER_1;
            data_d    = bus.data1_i;
        end else if (grant2) begin
            rr_last_d = OWNER_2;
            data_d    = bus.data2_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_last_q <= OWNER_2;
            data_q    <= '0;
            ack1_q    <= 1'b0;
            ack2_q    <= 1'b0;
            wr1_q     <= 1'b0;
            wr2_q     <= 1'b0;
            data1_q   <= '0;
            data2_q   <= '0;
            owner_q   <= OWNER_NONE;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            data_q    <= data_d;
            ack1_q    <= grant1;
            ack2_q    <= grant2;
            // Strobes are refreshed every owned cycle because the register clears without one.
            wr1_q     <= (state_d == OWN1);
            wr2_q     <= (state_d == OWN2);
            data1_q   <= (state_d == OWN1) ? data_d : '0;
            data2_q   <= (state_d == OWN2) ? data_d : '0;
            owner_q   <= (state_d == OWN1) ? OWNER_1 :
                         (state_d == OWN2) ? OWNER_2 : OWNER_NONE;
            busy_q    <= (state_d != IDLE) && !hold_zero_nxt;
        end
    end

    assign bus.ack1_o  = ack1_q;
    assign bus.ack2_o  = ack2_q;
    assign bus.wr1_o   = wr1_q;
    assign bus.wr2_o   = wr2_q;
    assign bus.data1_o = data1_q;
    assign bus.data2_o = data2_q;
    assign bus.owner_o = owner_q;
    assign bus.busy_o  = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural model of the downstream control register.
module tb_reg_write_arbiter;
    import reg_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_write_arbiter_if #(.DW(32)) bus();

    reg_write_arbiter #(.DW(32), .MIN_HOLD(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // Downstream register: takes the strobed data, clears whenever no strobe is high.
    logic [31:0] reg_q;
    always_ff @(posedge clk) begin
        if (rst)             reg_q <= '0;
        else if (bus.wr1_o)  reg_q <= bus.data1_o;
        else if (bus.wr2_o)  reg_q <= bus.data2_o;
        else                 reg_q <= '0;
    end

    int total = 0;
    int bad   = 0;

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (bus.wr1_o && bus.wr2_o) begin
                bad++;
                $display("FAIL strobe_exclusive wr1=%b wr2=%b want not both at %0t", bus.wr1_o, bus.wr2_o, $time);
            end
        end
    end

    // {ack1, ack2, wr1, wr2, owner[1:0], busy}
    function automatic logic [6:0] ctl();
        return {bus.ack1_o, bus.ack2_o, bus.wr1_o, bus.wr2_o, bus.owner_o, bus.busy_o};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req1_i  = 1'b0;
        bus.req2_i  = 1'b0;
        bus.data1_i = '0;
        bus.data2_i = '0;
        bus.rel_i   = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic go_idle();
        bit done = 1'b0;
        bus.rel_i = 1'b1;
        for (int i = 0; i < 16 && !done; i++) begin
            tick();
            if (bus.owner_o == OWNER_NONE) done = 1'b1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL go_idle owner=%b want=00 within 16 cycles", bus.owner_o);
        end
        bus.rel_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        total++;
        if (ctl() !== 7'b0000000) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=0000000", ctl());
        end
        total++;
        if ({bus.data1_o, bus.data2_o, reg_q} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data data1=%h data2=%h reg=%h want all 0", bus.data1_o, bus.data2_o, reg_q);
        end
    endtask

    task automatic test_single_grant();
        bus.req1_i  = 1'b1;
        bus.data1_i = 32'hDEAD_BEEF;
        tick();
        total++;
        if (ctl() !== 7'b1010011 || bus.data1_o !== 32'hDEAD_BEEF || reg_q !== 32'h0) begin
            bad++;
            $display("FAIL single_c1 ctl=%b data1=%h reg=%h want ctl=1010011 data1=deadbeef reg=0", ctl(), bus.data1_o, reg_q);
        end
        bus.req1_i = 1'b0;
        tick();
        total++;
        if (ctl() !== 7'b0010011 || reg_q !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL single_c2 ctl=%b reg=%h want ctl=0010011 reg=deadbeef", ctl(), reg_q);
        end
        go_idle();
    endtask

    task automatic test_round_robin();
        logic [6:0] exp_ctl [9] = '{7'b1010011, 7'b0010011, 7'b0010011, 7'b0010010,
                                    7'b0101101, 7'b0001101, 7'b0001101, 7'b0001100, 7'b1010011};
        do_reset();
        bus.req1_i  = 1'b1;
        bus.data1_i = 32'hAAAA_0001;
        bus.req2_i  = 1'b1;
        bus.data2_i = 32'hBBBB_0002;
        for (int c = 1; c <= 9; c++) begin
            tick();
            total++;
            if (ctl() !== exp_ctl[c-1]) begin
                bad++;
                $display("FAIL rr_ctl_c%0d got=%b want=%b", c, ctl(), exp_ctl[c-1]);
            end
            if (c == 1) bus.req1_i = 1'b0;
            if (c == 5) begin
                total++;
                if (bus.data2_o !== 32'hBBBB_0002 || bus.data1_o !== 32'h0) begin
                    bad++;
                    $display("FAIL rr_data_c5 data1=%h data2=%h want 0 / bbbb0002", bus.data1_o, bus.data2_o);
                end
                bus.req2_i  = 1'b0;
                bus.req1_i  = 1'b1;
                bus.data1_i = 32'hCCCC_0003;
            end
            if (c == 9) begin
                total++;
                if (bus.data1_o !== 32'hCCCC_0003) begin
                    bad++;
                    $display("FAIL rr_data_c9 data1=%h want=cccc0003", bus.data1_o);
                end
                bus.req1_i = 1'b0;
            end
        end
        go_idle();
    endtask

    task automatic test_hold_window();
        logic [6:0] exp_ctl [4] = '{7'b0010011, 7'b0010011, 7'b0010010, 7'b0101101};
        bus.req1_i  = 1'b1;
        bus.data1_i = 32'h1111_0001;
        tick();
        total++;
        if (ctl() !== 7'b1010011) begin
            bad++;
            $display("FAIL hold_grant got=%b want=1010011", ctl());
        end
        bus.req1_i  = 1'b0;
        bus.req2_i  = 1'b1;
        bus.data2_i = 32'hD00D_0004;
        for (int c = 2; c <= 5; c++) begin
            tick();
            total++;
            if (ctl() !== exp_ctl[c-2]) begin
                bad++;
                $display("FAIL hold_ctl_c%0d got=%b want=%b", c, ctl(), exp_ctl[c-2]);
            end
        end
        total++;
        if (bus.data1_o !== 32'h0 || bus.data2_o !== 32'hD00D_0004 || reg_q !== 32'h1111_0001) begin
            bad++;
            $display("FAIL hold_switch data1=%h data2=%h reg=%h want 0 / d00d0004 / 11110001", bus.data1_o, bus.data2_o, reg_q);
        end
        bus.req2_i = 1'b0;
    endtask

    task automatic test_release();
        logic [6:0]  exp_ctl [5] = '{7'b0001101, 7'b0001101, 7'b0001100, 7'b0000000, 7'b0000000};
        logic [31:0] exp_reg [5] = '{32'hD00D_0004, 32'hD00D_0004, 32'hD00D_0004, 32'hD00D_0004, 32'h0};
        // Raised while the window is still open: must be ignored until hold expires.
        bus.rel_i = 1'b1;
        for (int c = 6; c <= 10; c++) begin
            tick();
            total++;
            if (ctl() !== exp_ctl[c-6] || reg_q !== exp_reg[c-6]) begin
                bad++;
                $display("FAIL rel_c%0d ctl=%b reg=%h want ctl=%b reg=%h", c, ctl(), reg_q, exp_ctl[c-6], exp_reg[c-6]);
            end
        end
        bus.rel_i = 1'b0;
        tick();
    endtask

    task automatic test_preempt_and_rerequest();
        logic [6:0] exp_ctl [4] = '{7'b0010011, 7'b0010011, 7'b0010010, 7'b0101101};
        bus.req1_i  = 1'b1;
        bus.data1_i = 32'hEEEE_0005;
        tick();
        total++;
        if (ctl() !== 7'b1010011) begin
            bad++;
            $display("FAIL pre_grant got=%b want=1010011", ctl());
        end
        bus.req1_i = 1'b0;
        bus.rel_i  = 1'b1;
        for (int c = 2; c <= 5; c++) begin
            tick();
            total++;
            if (ctl() !== exp_ctl[c-2]) begin
                bad++;
                $display("FAIL pre_ctl_c%0d got=%b want=%b", c, ctl(), exp_ctl[c-2]);
            end
            if (c == 2) begin
                bus.req2_i  = 1'b1;
                bus.data2_i = 32'hF00F_0006;
            end
        end
        total++;
        if (bus.data2_o !== 32'hF00F_0006) begin
            bad++;
            $display("FAIL pre_data data2=%h want=f00f0006", bus.data2_o);
        end
        bus.req2_i = 1'b0;
        bus.rel_i  = 1'b0;
        tick();
        // Owner re-request inside the window
        bus.req2_i  = 1'b1;
        bus.data2_i = 32'h6666_0007;
        tick();
        total++;
        if (ctl() !== 7'b0101101 || bus.data2_o !== 32'h6666_0007) begin
            bad++;
            $display("FAIL rereq_ack ctl=%b data2=%h want ctl=0101101 data2=66660007", ctl(), bus.data2_o);
        end
        bus.req2_i = 1'b0;
        tick();
        tick();
        total++;
        if (bus.busy_o !== 1'b1) begin
            bad++;
            $display("FAIL rereq_reload busy=%b want=1", bus.busy_o);
        end
        tick();
        total++;
        if (ctl() !== 7'b0001100) begin
            bad++;
            $display("FAIL rereq_expired got=%b want=0001100", ctl());
        end
        // Owner's own request beats a simultaneous release
        bus.rel_i   = 1'b1;
        bus.req2_i  = 1'b1;
        bus.data2_i = 32'h7777_0008;
        tick();
        total++;
        if (ctl() !== 7'b0101101 || bus.data2_o !== 32'h7777_0008) begin
            bad++;
            $display("FAIL req_over_rel ctl=%b data2=%h want ctl=0101101 data2=77770008", ctl(), bus.data2_o);
        end
        bus.req2_i = 1'b0;
        go_idle();
    endtask

    task automatic test_reset_mid_op();
        bus.req2_i  = 1'b1;
        bus.data2_i = 32'h2222_0009;
        tick();
        total++;
        if (ctl() !== 7'b0101101) begin
            bad++;
            $display("FAIL rst_own2 got=%b want=0101101", ctl());
        end
        bus.req2_i  = 1'b0;
        bus.req1_i  = 1'b1;
        bus.data1_i = 32'h3333_000A;
        tick();
        total++;
        if (ctl() !== 7'b0001101) begin
            bad++;
            $display("FAIL rst_pending got=%b want=0001101", ctl());
        end
        rst = 1'b1;
        tick();
        total++;
        if (ctl() !== 7'b0000000 || {bus.data1_o, bus.data2_o, reg_q} !== 96'h0) begin
            bad++;
            $display("FAIL rst_mid ctl=%b data1=%h data2=%h reg=%h want all 0", ctl(), bus.data1_o, bus.data2_o, reg_q);
        end
        rst = 1'b0;
        tick();
        total++;
        if (ctl() !== 7'b1010011 || bus.data1_o !== 32'h3333_000A) begin
            bad++;
            $display("FAIL rst_regrant ctl=%b data1=%h want ctl=1010011 data1=3333000a", ctl(), bus.data1_o);
        end
        bus.req1_i = 1'b0;
        go_idle();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_grant();
        test_round_robin();
        test_hold_window();
        test_release();
        test_preempt_and_rerequest();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
